// File: rtl/trng_bit_collector16_pkg.sv
// Shared types and build defaults for the TRNG bit collector.
// AUTOCORR_192_BITS selects a 12-word (192-bit) or 16-word (256-bit) autocorrelation round.
package trng_bit_collector16_pkg;

  localparam bit AUTOCORR_192_BITS   = 1'b1;
  localparam int DEF_WORDS_PER_ROUND = AUTOCORR_192_BITS ? 12 : 16;
  localparam int DEF_SMPL_W          = 16;
  localparam int DEF_MIN_SMPL        = 2;

  typedef enum logic [1:0] {
    COLL_IDLE    = 2'd0,
    COLL_COLLECT = 2'd1,
    COLL_HOLD    = 2'd2
  } coll_state_t;

endpackage

// File: rtl/trng_sample_strobe.sv
// Sample-rate divider: strobes on the last cycle of each period; the period is clamped
// to MIN_SMPL and re-latched from sample_cnt_limit only at a wrap, a clear or while disabled.
module trng_sample_strobe #(
  parameter int SMPL_W   = 16,
  parameter int MIN_SMPL = 2
) (
  input  logic              rng_clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [SMPL_W-1:0] sample_cnt_limit,
  output logic              strobe
);

  localparam logic [SMPL_W-1:0] MIN_P = SMPL_W'(MIN_SMPL);

  logic [SMPL_W-1:0] smpl_cnt;
  logic [SMPL_W-1:0] period;
  logic [SMPL_W-1:0] period_next;

  assign period_next = (sample_cnt_limit < MIN_P) ? MIN_P : sample_cnt_limit;
  assign strobe      = en && (smpl_cnt == period - 1'b1);

  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      smpl_cnt <= '0;
      period   <= MIN_P;
    end else if (clear || !en || strobe) begin
      smpl_cnt <= '0;
      period   <= period_next;
    end else begin
      smpl_cnt <= smpl_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/trng_bit_collector16.sv
// Packs sampled noise bits into 16-bit words and counts words per autocorrelation round,
// holding accum_enough_bits until the test reports completion or failure.
module trng_bit_collector16
  import trng_bit_collector16_pkg::*;
#(
  parameter int WORDS_PER_ROUND = DEF_WORDS_PER_ROUND,
  parameter int SMPL_W          = DEF_SMPL_W,
  parameter int MIN_SMPL        = DEF_MIN_SMPL
) (
  input  logic              rng_clk,
  input  logic              rst,
  input  logic              rnd_src_en,
  input  logic              rst_trng_logic,
  input  logic              rnd_bit,
  input  logic [SMPL_W-1:0] sample_cnt_limit,
  input  logic              curr_test_err,
  input  logic              autocorr_finish_curr,
  output logic [15:0]       data_in16bit,
  output logic              valid_16bit,
  output logic              accum_enough_bits,
  output logic              collector_busy,
  output coll_state_t       dbg_state
);

  localparam int WC_W = $clog2(WORDS_PER_ROUND + 1);

  coll_state_t      state;
  logic [15:0]      shreg;
  logic [3:0]       bit_cnt;
  logic [WC_W-1:0]  word_cnt;
  logic             flush;
  logic             strobe;

  assign flush     = rst_trng_logic || !rnd_src_en;
  assign dbg_state = state;

  trng_sample_strobe #(
    .SMPL_W   (SMPL_W),
    .MIN_SMPL (MIN_SMPL)
  ) u_strobe (
    .rng_clk          (rng_clk),
    .rst              (rst),
    .en               (state == COLL_COLLECT),
    .clear            (flush || curr_test_err),
    .sample_cnt_limit (sample_cnt_limit),
    .strobe           (strobe)
  );

  // valid_16bit is a one-cycle pulse with no ready: the consumer must take data_in16bit
  // within the 16 cycles that follow; the minimum period keeps the word stable that long.
  always_ff @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      state             <= COLL_IDLE;
      shreg             <= '0;
      bit_cnt           <= '0;
      word_cnt          <= '0;
      data_in16bit      <= '0;
      valid_16bit       <= 1'b0;
      accum_enough_bits <= 1'b0;
      collector_busy    <= 1'b0;
    end else if (flush) begin
      state             <= COLL_IDLE;
      shreg             <= '0;
      bit_cnt           <= '0;
      word_cnt          <= '0;
      data_in16bit      <= '0;
      valid_16bit       <= 1'b0;
      accum_enough_bits <= 1'b0;
      collector_busy    <= 1'b0;
    end else begin
      valid_16bit <= 1'b0;
      case (state)
        COLL_IDLE: begin
          state          <= COLL_COLLECT;
          collector_busy <= 1'b1;
        end
        COLL_COLLECT: begin
          if (curr_test_err) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end else if (strobe) begin
            shreg   <= {rnd_bit, shreg[15:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 4'hF) begin
              data_in16bit <= {rnd_bit, shreg[15:1]};
              valid_16bit  <= 1'b1;
              word_cnt     <= word_cnt + 1'b1;
              if (word_cnt == WC_W'(WORDS_PER_ROUND - 1)) begin
                state          <= COLL_HOLD;
                collector_busy <= 1'b0;
              end
            end
          end
        end
        COLL_HOLD: begin
          // accum rises the cycle after the final valid pulse, not with it
          if (autocorr_finish_curr || curr_test_err) begin
            state             <= COLL_COLLECT;
            collector_busy    <= 1'b1;
            accum_enough_bits <= 1'b0;
            word_cnt          <= '0;
            bit_cnt           <= '0;
          end else begin
            accum_enough_bits <= 1'b1;
          end
        end
        default: begin
          state          <= COLL_IDLE;
          collector_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_bit_collector16.sv
// Bench for trng_bit_collector16: directed scenarios plus randomized traffic, all checked
// every cycle against a bit-queue model of the sampling, packing and round rules.
module tb_trng_bit_collector16;
  import trng_bit_collector16_pkg::*;

  localparam int WPR = 12;

  logic        rng_clk = 1'b0;
  logic        rst = 1'b1;
  logic        rnd_src_en = 1'b1;
  logic        rst_trng_logic = 1'b0;
  logic        rnd_bit = 1'b0;
  logic [15:0] sample_cnt_limit = 16'd2;
  logic        curr_test_err = 1'b0;
  logic        autocorr_finish_curr = 1'b0;
  logic [15:0] data_in16bit;
  logic        valid_16bit;
  logic        accum_enough_bits;
  logic        collector_busy;
  coll_state_t dbg_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit rand_bits = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 rng_clk = ~rng_clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  trng_bit_collector16 dut (
    .rng_clk              (rng_clk),
    .rst                  (rst),
    .rnd_src_en           (rnd_src_en),
    .rst_trng_logic       (rst_trng_logic),
    .rnd_bit              (rnd_bit),
    .sample_cnt_limit     (sample_cnt_limit),
    .curr_test_err        (curr_test_err),
    .autocorr_finish_curr (autocorr_finish_curr),
    .data_in16bit         (data_in16bit),
    .valid_16bit          (valid_16bit),
    .accum_enough_bits    (accum_enough_bits),
    .collector_busy       (collector_busy),
    .dbg_state            (dbg_state)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode 0 = waiting to start, 1 = gathering bits, 2 = round full
  int          m_mode = 0;
  int          m_phase = 0;
  int          m_per = 2;
  int          m_words = 0;
  logic        m_bits[$];
  logic [15:0] exp_q[$];
  logic        m_valid = 1'b0;
  logic        m_accum = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_data = '0;
  logic [15:0] m_w;

  function automatic int eff_period(input logic [15:0] lim);
    return (lim < 16'd2) ? 2 : int'(lim);
  endfunction

  task automatic model_flush();
    m_mode = 0; m_phase = 0; m_words = 0;
    m_per = eff_period(sample_cnt_limit);
    m_bits.delete(); exp_q.delete();
    m_valid = 1'b0; m_accum = 1'b0; m_busy = 1'b0; m_data = '0;
  endtask

  task automatic new_round();
    m_bits.delete();
    m_words = 0;
    m_phase = 0;
    m_per = eff_period(sample_cnt_limit);
  endtask

  always @(posedge rng_clk or posedge rst) begin
    if (rst) begin
      model_flush();
    end else begin
      cyc++;
      m_valid = 1'b0;
      if (rst_trng_logic || !rnd_src_en) begin
        model_flush();
      end else if (m_mode == 0) begin
        m_mode = 1; m_busy = 1'b1; m_phase = 0;
        m_per = eff_period(sample_cnt_limit);
      end else if (m_mode == 1) begin
        if (curr_test_err) begin
          new_round();
        end else if (m_phase == m_per - 1) begin
          // the bit is taken on the last cycle of each period
          m_bits.push_back(rnd_bit);
          m_phase = 0;
          m_per = eff_period(sample_cnt_limit);
          if (m_bits.size() == 16) begin
            for (int i = 0; i < 16; i++) m_w[i] = m_bits[i];
            m_bits.delete();
            m_data = m_w;
            exp_q.push_back(m_w);
            m_valid = 1'b1;
            m_words++;
            if (m_words == WPR) begin m_mode = 2; m_busy = 1'b0; end
          end
        end else begin
          m_phase++;
        end
      end else begin
        m_per = eff_period(sample_cnt_limit);
        if (autocorr_finish_curr || curr_test_err) begin
          new_round();
          m_mode = 1; m_busy = 1'b1; m_accum = 1'b0;
        end else begin
          m_accum = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [15:0] sb_w;
  always @(negedge rng_clk) begin
    check("valid_16bit", 16'(valid_16bit), 16'(m_valid));
    check("accum_enough_bits", 16'(accum_enough_bits), 16'(m_accum));
    check("collector_busy", 16'(collector_busy), 16'(m_busy));
    check("data_in16bit", data_in16bit, m_data);
    if (m_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL word_queue: expected-word queue empty at cycle %0d", cyc);
      end else begin
        sb_w = exp_q.pop_front();
        check("word", data_in16bit, sb_w);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rng_clk);
      #1;
      if (rand_bits) rnd_bit = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic flush_pulse();
    rst_trng_logic = 1'b1;
    tick(1);
    rst_trng_logic = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick(1);
      if (valid_16bit) begin at = cyc; break; end
    end
    tests++;
    if (at < 0) begin
      fails++;
      $display("FAIL wait_valid: no valid_16bit within %0d cycles (cycle %0d)", max, cyc);
    end
  endtask

  task automatic count_valids(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick(1);
      if (valid_16bit) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  int start, vc, prev, cnt, e;

  initial begin
    // T1: reset values, start-up, asynchronous reset mid-collection
    tick(3);
    check("t1_reset_state", 16'(dbg_state), 16'(COLL_IDLE));
    check("t1_reset_busy", 16'(collector_busy), 16'd0);
    rst = 1'b0;
    tick(1);
    check("t1_busy_after_release", 16'(collector_busy), 16'd1);
    tick(10);
    rst = 1'b1;
    #1;
    check("t1_async_busy", 16'(collector_busy), 16'd0);
    check("t1_async_valid", 16'(valid_16bit), 16'd0);
    check("t1_async_accum", 16'(accum_enough_bits), 16'd0);
    check("t1_async_data", data_in16bit, 16'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("t1_busy_restart", 16'(collector_busy), 16'd1);

    // T2: packing order and word latency at period 2
    sample_cnt_limit = 16'd2;
    rnd_bit = 1'b1;
    flush_pulse();
    tick(1);
    start = cyc;
    tick(2);
    rnd_bit = 1'b0;
    wait_valid(100, vc);
    check("t2_latency", 16'(vc - start), 16'd32);
    check("t2_data", data_in16bit, 16'h0001);
    prev = vc;
    wait_valid(100, vc);
    check("t2_spacing", 16'(vc - prev), 16'd32);
    check("t2_data2", data_in16bit, 16'h0000);

    // T3: full round at period 4, hold, release
    rand_bits = 1'b1;
    sample_cnt_limit = 16'd4;
    flush_pulse();
    tick(1);
    prev = cyc;
    for (int k = 0; k < WPR; k++) begin
      wait_valid(200, vc);
      check("t3_spacing", 16'(vc - prev), 16'd64);
      prev = vc;
    end
    check("t3_accum_with_last_valid", 16'(accum_enough_bits), 16'd0);
    tick(1);
    check("t3_accum_rise", 16'(accum_enough_bits), 16'd1);
    count_valids(500, cnt);
    check("t3_no_valid_in_hold", 16'(cnt), 16'd0);
    check("t3_accum_held", 16'(accum_enough_bits), 16'd1);
    autocorr_finish_curr = 1'b1;
    tick(1);
    autocorr_finish_curr = 1'b0;
    e = cyc;
    check("t3_accum_fall", 16'(accum_enough_bits), 16'd0);
    check("t3_busy_restart", 16'(collector_busy), 16'd1);
    wait_valid(200, vc);
    check("t3_restart_latency", 16'(vc - e), 16'd64);

    // T4: error after word 5 discards the partial round
    flush_pulse();
    for (int k = 0; k < 5; k++) wait_valid(200, vc);
    curr_test_err = 1'b1;
    tick(1);
    curr_test_err = 1'b0;
    e = cyc;
    wait_valid(200, vc);
    check("t4_latency_after_err", 16'(vc - e), 16'd64);
    check("t4_accum_early", 16'(accum_enough_bits), 16'd0);
    for (int k = 1; k < WPR; k++) wait_valid(200, vc);
    check("t4_accum_at_12th", 16'(accum_enough_bits), 16'd0);
    tick(1);
    check("t4_accum_after_12", 16'(accum_enough_bits), 16'd1);

    // T6: flush from HOLD, then source disabled
    rst_trng_logic = 1'b1;
    tick(1);
    rst_trng_logic = 1'b0;
    check("t6_accum_flushed", 16'(accum_enough_bits), 16'd0);
    check("t6_state_idle", 16'(dbg_state), 16'(COLL_IDLE));
    tick(1);
    check("t6_busy_again", 16'(collector_busy), 16'd1);
    rnd_src_en = 1'b0;
    tick(1);
    check("t6_busy_disabled", 16'(collector_busy), 16'd0);
    count_valids(100, cnt);
    check("t6_no_valid_disabled", 16'(cnt), 16'd0);
    rnd_src_en = 1'b1;

    // T5: clamp of limit 0 and error colliding with the 16th strobe
    sample_cnt_limit = 16'd0;
    flush_pulse();
    tick(1);
    start = cyc;
    wait_valid(100, vc);
    check("t5_clamp_latency", 16'(vc - start), 16'd32);
    prev = vc;
    wait_valid(100, vc);
    check("t5_clamp_spacing", 16'(vc - prev), 16'd32);
    prev = vc;
    tick(31);
    curr_test_err = 1'b1;
    tick(1);
    curr_test_err = 1'b0;
    check("t5_dropped_word", 16'(valid_16bit), 16'd0);
    wait_valid(100, vc);
    check("t5_after_drop", 16'(vc - prev), 16'd64);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      curr_test_err        = ($urandom_range(0, 1999) == 0);
      autocorr_finish_curr = ($urandom_range(0, 19) == 0);
      rst_trng_logic       = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 199) == 0) sample_cnt_limit = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 999) == 0) rnd_src_en = 1'b0;
      else if (!rnd_src_en && $urandom_range(0, 3) == 0) rnd_src_en = 1'b1;
      if (i == 2000) begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
      end
      tick(1);
    end
    curr_test_err = 1'b0;
    autocorr_finish_curr = 1'b0;
    rst_trng_logic = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
